fft_result_out: RTL

- Output-side counterpart of the FFT_BASE2 core: the core writes butterfly results into this block, and this block streams them out.
- The core writes each finished frame of N complex results into one of two banks, at bit-reversed addresses, then pulses frame_done.
- The block reorders each frame to natural frequency order and streams it on a valid/ready interface with index and last markers.
- Double buffering lets the core fill the next frame while the current one drains.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_bank_ram.sv | 25 ++
 rtl/fft_result_out.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: sizes, the packed complex
// sample, the output-stage FSM encoding and the bit-reversal helper.
package fft_pkg;

    localparam int FFT_N_DEF   = 16;
    localparam int FFT_DW_DEF  = 8;
    localparam int CMD_WIDTH   = $clog2(FFT_N_DEF);

    // One complex sample, real part in the upper half.
    typedef struct packed {
        logic [FFT_DW_DEF-1:0] i;
        logic [FFT_DW_DEF-1:0] q;
    } cplx_t;

    // Output streaming FSM.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } out_state_t;

    // Reverse the low nbits bits of k; bits above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned nbits);
        logic [31:0] r;
        r = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < nbits) r[nbits - 1 - b] = k[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One result bank: DEPTH words, synchronous write, combinational read.
// Contents are not reset; every frame overwrites what it needs.
module fft_bank_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store a word on a write strobe.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_result_out.sv
// Double-buffered FFT result reorder/stream stage. The core fills one bank
// at bit-reversed addresses and closes it with frame_done; the other bank
// is read out in natural frequency order on a valid/ready stream.
//
// Stream handshake: a beat transfers on a rising clk edge where out_valid
// and out_ready are both 1. While out_valid=1 and out_ready=0 the beat
// (out_i, out_q, out_index, out_last) is held unchanged. out_valid never
// depends combinationally on out_ready.
module fft_result_out
    import fft_pkg::*;
#(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BITREV     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(N)-1:0]    wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    input  logic                    frame_done,
    output logic                    in_ready,
    output logic                    overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_i,
    output logic [DATA_WIDTH-1:0]   out_q,
    output logic [$clog2(N)-1:0]    out_index,
    output logic                    out_last
);

    localparam int AW  = $clog2(N);
    localparam int DW2 = 2 * DATA_WIDTH;

    logic [1:0]     full;
    logic [1:0]     full_nxt;
    logic           wr_bank;
    logic           rd_bank;
    out_state_t     state;
    logic [AW-1:0]  cnt;
    logic [AW-1:0]  rd_addr;
    logic [DW2-1:0] rdata0;
    logic [DW2-1:0] rdata1;
    logic [DW2-1:0] rd_data;
    logic [DW2-1:0] out_data;
    logic           we0;
    logic           we1;
    logic           accept_done;
    logic           drain_done;

    // A bank only accepts writes while it is still open (not full).
    assign we0 = wr_en && (wr_bank == 1'b0) && !full[0];
    assign we1 = wr_en && (wr_bank == 1'b1) && !full[1];

    // frame_done closes the open bank; it is dropped if that bank is still full.
    assign accept_done = frame_done && !full[wr_bank];
    // Final beat of the frame leaves the read bank.
    assign drain_done  = (state == STREAM) && out_valid && out_ready && out_last;

    assign in_ready = !full[wr_bank];

    // cnt is 0 while idle, so the IDLE load naturally fetches bin 0.
    assign rd_addr = (BITREV != 0) ? AW'(bitrev(32'(cnt), AW)) : cnt;
    assign rd_data = rd_bank ? rdata1 : rdata0;

    assign out_i = out_data[DW2-1:DATA_WIDTH];
    assign out_q = out_data[DATA_WIDTH-1:0];

    fft_bank_ram #(.DEPTH(N), .WIDTH(DW2), .ADDR_W(AW)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    fft_bank_ram #(.DEPTH(N), .WIDTH(DW2), .ADDR_W(AW)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    // Next full flags: a drain clear and a frame_done set can land together.
    always_comb begin
        full_nxt = full;
        if (drain_done)  full_nxt[rd_bank] = 1'b0;
        if (accept_done) full_nxt[wr_bank] = 1'b1;
    end

    // Bank ownership flags and the overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            full     <= full_nxt;
            overflow <= frame_done && full[wr_bank];
            if (accept_done) wr_bank <= ~wr_bank;
            if (drain_done)  rd_bank <= ~rd_bank;
        end
    end

    // Output FSM: wait for a full bank, then stream bins 0..N-1 in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        out_data  <= rd_data;
                        out_index <= '0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        cnt       <= AW'(1);
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            out_data  <= rd_data;
                            out_index <= cnt;
                            out_last  <= (cnt == AW'(N - 1));
                            cnt       <= cnt + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
